// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } rst_state_e;

  // Counter must reach the larger of the two terminal values without wrapping.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_hold_counter.sv
// Clear/enable up-counter that flags when its count equals a runtime limit.
module rst_hold_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         terminal_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign terminal_o = (count_q == limit_i);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all downstream reset domains, then releases them one by one in index order.
// Soft re-sequence (SOFT state, soft_ack) is compiled in with RSTSEQ_SOFT_RESET_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 6,
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned STAGE_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_req,
  output logic                  soft_ack,
  output logic [NUM_STAGES-1:0] stage_resetn,
  output logic                  all_ready,
  output logic [1:0]            state
);

  localparam int unsigned CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int unsigned IW = $clog2(NUM_STAGES + 1);

  rst_state_e            state_q, state_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_limit;
  logic                  cnt_clr, cnt_en, cnt_term;
  logic                  last_done;

`ifdef RSTSEQ_SOFT_RESET_EN
  logic soft_q, soft_d;
`else
  logic unused_soft_req;
  assign unused_soft_req = soft_req;
`endif

  assign last_done = (idx_q == IW'(NUM_STAGES));
  assign cnt_limit = (state_q == ST_RELEASE) ? CW'(STAGE_GAP - 1) : CW'(HOLD_CYCLES - 1);
  assign cnt_en    = (state_q != ST_RUN);
  // Restart the count on every terminal and on every state change.
  assign cnt_clr   = cnt_term || (state_d != state_q);

  rst_hold_counter #(.W(CW)) u_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .limit_i    (cnt_limit),
    .terminal_o (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HOLD;
      stage_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      idx_q   <= '0;
`ifdef RSTSEQ_SOFT_RESET_EN
      soft_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      idx_q   <= idx_d;
`ifdef RSTSEQ_SOFT_RESET_EN
      soft_q  <= soft_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD, ST_SOFT: if (cnt_term) state_d = ST_RELEASE;
      ST_RELEASE:       if (last_done) state_d = ST_RUN;
      ST_RUN: begin
`ifdef RSTSEQ_SOFT_RESET_EN
        if (soft_req) state_d = ST_SOFT;
`endif
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Next values of the registered outputs, index and soft-origin flag.
  always_comb begin
    stage_d = stage_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    idx_d   = idx_q;
`ifdef RSTSEQ_SOFT_RESET_EN
    soft_d  = soft_q;
`endif
    case (state_q)
      ST_HOLD, ST_SOFT: begin
        if (cnt_term) begin
          stage_d = NUM_STAGES'(1);
          idx_d   = IW'(1);
        end
      end
      ST_RELEASE: begin
        if (last_done) begin
          ready_d = 1'b1;
`ifdef RSTSEQ_SOFT_RESET_EN
          ack_d   = soft_q;
          soft_d  = 1'b0;
`endif
        end else if (cnt_term) begin
          stage_d = stage_q | (NUM_STAGES'(1) << idx_q);
          idx_d   = idx_q + IW'(1);
        end
      end
      ST_RUN: begin
`ifdef RSTSEQ_SOFT_RESET_EN
        if (soft_req) begin
          stage_d = '0;
          ready_d = 1'b0;
          idx_d   = '0;
          soft_d  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  assign stage_resetn = stage_q;
  assign all_ready    = ready_q;
  assign soft_ack     = ack_q;
  assign state        = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a HOLD_CYCLES=1/NUM_STAGES=1 instance.
module tb_reset_sequencer;

`ifdef RSTSEQ_SOFT_RESET_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       soft_req;
  logic [2:0] sr0;
  logic       ar0, ack0;
  logic [1:0] st0;
  logic [0:0] sr1;
  logic       ar1, ack1;
  logic [1:0] st1;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: time since the current sequence started and its origin.
  int pH [2] = '{6, 1};
  int pN [2] = '{3, 1};
  int pG [2] = '{4, 4};
  int t  [2] = '{0, 0};
  bit sorg [2] = '{1'b0, 1'b0};

  reset_sequencer #(.HOLD_CYCLES(6), .NUM_STAGES(3), .STAGE_GAP(4)) dut0 (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_ack(ack0),
    .stage_resetn(sr0), .all_ready(ar0), .state(st0)
  );

  reset_sequencer #(.HOLD_CYCLES(1), .NUM_STAGES(1), .STAGE_GAP(4)) dut1 (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_ack(ack1),
    .stage_resetn(sr1), .all_ready(ar1), .state(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int t_run(input int i);
    return pH[i] + (pN[i] - 1) * pG[i] + 1;
  endfunction

  function automatic logic [7:0] exp_stage(input int i);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < pN[i]; k++) v[k] = (t[i] >= pH[i] + k * pG[i]);
    return v;
  endfunction

  function automatic logic [7:0] exp_state(input int i);
    if (t[i] < pH[i])     return sorg[i] ? 8'd3 : 8'd0;
    if (t[i] < t_run(i))  return 8'd1;
    return 8'd2;
  endfunction

  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d cycle=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        t[i] = 0;
        sorg[i] = 1'b0;
      end else if (SOFT_EN && s && t[i] >= t_run(i)) begin
        t[i] = 0;
        sorg[i] = 1'b1;
      end else if (t[i] < 100000) begin
        t[i]++;
      end
    end
  endtask

  task automatic check_all();
    chk("stage_resetn", 0, {5'b0, sr0}, exp_stage(0));
    chk("all_ready",    0, {7'b0, ar0}, {7'b0, t[0] >= t_run(0)});
    chk("soft_ack",     0, {7'b0, ack0}, {7'b0, sorg[0] && t[0] == t_run(0)});
    chk("state",        0, {6'b0, st0}, exp_state(0));
    chk("stage_resetn", 1, {7'b0, sr1}, exp_stage(1));
    chk("all_ready",    1, {7'b0, ar1}, {7'b0, t[1] >= t_run(1)});
    chk("soft_ack",     1, {7'b0, ack1}, {7'b0, sorg[1] && t[1] == t_run(1)});
    chk("state",        1, {6'b0, st1}, exp_state(1));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check mid-cycle.
  task automatic cycle(input bit r, input bit s);
    reset    = r;
    soft_req = s;
    @(posedge clk);
    model_step(r, s);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  initial begin
    reset    = 1'b1;
    soft_req = 1'b0;

    // Power-on reset then a full sequence.
    repeat (6) cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);

    // Reset reasserted during cycle 8, then a clean restart.
    repeat (6) cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);

    // Single soft request pulse while in RUN.
    cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);

    // Soft request held from reset release: ignored until RUN.
    cycle(1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);

    // Reset aborting a soft re-sequence: no soft_ack afterwards.
    cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);

    // Randomized reset and soft request traffic.
    repeat (600) cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-on and soft reset sequencer. It sits directly downstream of the testbench/system clock and reset generator. After the global reset is released, it holds every downstream domain in reset for a fixed interval, then releases the domains one at a time in index order, with a fixed gap between releases. When the last domain is out of reset it flags `all_ready`. With the macro compiled in, a running system can request a full re-sequence through a req/ack handshake.

## Interface
Parameters:
- `HOLD_CYCLES`, default 6: cycles all stages stay in reset after reset/soft request. At a 10 ns clock this is 60 ns. Legal range ≥1.
- `NUM_STAGES`, default 3: number of downstream reset domains. Legal range 1..8.
- `STAGE_GAP`, default 4: cycles between consecutive stage releases. Legal range ≥1.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high; overrides everything.
- `soft_req`, input, 1: soft re-sequence request, sampled each edge.
- `soft_ack`, output, 1: one-cycle pulse when a soft re-sequence completes.
- `stage_resetn`, output, `NUM_STAGES`: active-low per-domain resets; bit 0 is released first.
- `all_ready`, output, 1: high while every stage is released and the FSM is in RUN.
- `state`, output, 2: FSM state for debug; HOLD=0, RELEASE=1, RUN=2, SOFT=3.

## Operation
- Reset values while `reset` is high, registered on the edge: `stage_resetn`=0, `all_ready`=0, `soft_ack`=0, `state`=HOLD, counter=0, stage index=0.
- HOLD: the counter increments each cycle. The first cycle with `reset` low is hold cycle 0. On the edge ending cycle `HOLD_CYCLES`-1:
  - `stage_resetn[0]` goes to 1.
  - state goes to RELEASE, counter=0, index=1.
- RELEASE: the counter increments. When counter reaches `STAGE_GAP`-1:
  - `stage_resetn[index]` goes to 1, index++, counter=0.
  - After the last stage is released, the next edge goes to RUN and sets `all_ready`=1.
  - With `NUM_STAGES`=1, HOLD goes to RELEASE and then RUN on the next edge.
- RUN: outputs are static.
  - A `soft_req` sampled high moves the FSM to SOFT.
  - On that same edge, `stage_resetn` goes to 0 and `all_ready` goes to 0.
- SOFT: identical to HOLD (the counter restarts at 0), then proceeds through RELEASE. A soft-origin flag is set.
  - On the edge entering RUN, `soft_ack` goes to 1 for exactly one cycle and the flag clears.
- `soft_req` outside RUN is ignored; it is not queued. `soft_req` held high in RUN starts exactly one re-sequence per RUN entry.
- `reset` asserted mid-sequence, in any state (including SOFT), aborts on the next edge to reset values. A pending soft-origin flag is cleared and no `soft_ack` is produced.
- Released stages never re-assert individually; only `reset` or a soft request re-asserts them, and then all together.

## Timing
- Cycle 0 is the first cycle with `reset` low. Stage k is released (visible) at cycle `HOLD_CYCLES` + k·`STAGE_GAP`.
- `all_ready` rises at cycle `HOLD_CYCLES` + (`NUM_STAGES`-1)·`STAGE_GAP` + 1.
- Soft request sampled on the edge ending cycle T:
  - Stages assert from T+1.
  - Stage k releases at T+1+`HOLD_CYCLES`+k·`STAGE_GAP`.
  - `all_ready` and `soft_ack` rise one cycle after the last release.
- Counter width is $clog2(max(`HOLD_CYCLES`,`STAGE_GAP`)+1). The counter never wraps because it clears on each terminal count.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `RSTSEQ_SOFT_RESET_EN` defined: the SOFT state, the soft-origin flag and the `soft_ack` logic are compiled in.
- Undefined: ports remain, `soft_req` is ignored, `soft_ack` is tied to 0, SOFT is unreachable, and `state` never shows 3.

## Structure
- Package `reset_seq_pkg` holds:
  - the `rst_state_e` enum (HOLD, RELEASE, RUN, SOFT; 2 bits);
  - the counter-width localparam function.
- Sub-module `rst_hold_counter`: clear/enable up-counter with a `terminal` flag at a parameterised limit. It is instantiated once, and its limit is muxed between `HOLD_CYCLES`-1 and `STAGE_GAP`-1 by state.

## Test plan
All scenarios use defaults, a 10 ns clock and the macro defined unless stated.
- Reset high 6 cycles, then low at cycle 0 → `stage_resetn`=000 through cycle 5, 001 at 6, 011 at 10, 111 at 14; `all_ready` 0→1 at 15; `soft_ack` stays 0.
- Reset reasserted at cycle 8 (stage 0 released) → next edge `stage_resetn`=000, `state`=HOLD. After release, timing restarts from cycle 0 exactly as above.
- In RUN, `soft_req` pulsed on edge ending cycle T → `stage_resetn`=000 at T+1, `state`=3. Releases at T+7, T+11, T+15; `all_ready` and `soft_ack` high at T+16; `soft_ack` low at T+17.
- `soft_req` held high during HOLD/RELEASE → timing identical to the first scenario, `soft_ack`=0; a re-sequence starts only once RUN is reached.
- `HOLD_CYCLES`=1, `NUM_STAGES`=1 → `stage_resetn`=1 at cycle 1, `all_ready`=1 at cycle 2.
- Macro undefined, `soft_req` pulsed in RUN → outputs unchanged, `soft_ack`=0, `state` remains 2.
